// File: rtl/clk_div_pkg.sv
// ---------------------------------------------------------------------------
// clk_div_pkg
// Shared types and defaults for the divided-clock monitor.
//   mon_state_t     : monitor FSM states (IDLE, MEASURE, LOCKED)
//   *_DEF constants : default parameter values for clock_divide_monitor
//   period_ok()     : judges one measured cycle against the expected divide
// ---------------------------------------------------------------------------
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } mon_state_t;

    localparam int DIV_DEF        = 3;
    localparam int CNT_W_DEF      = 8;
    localparam int LOCK_COUNT_DEF = 4;
    localparam int TIMEOUT_DEF    = 12;

    // A cycle is good when its period matches the divide ratio and its high
    // time is within half a source cycle of 50% duty (odd ratios allow
    // either floor or ceil of DIV/2).
    function automatic logic period_ok(input int meas_period,
                                       input int meas_high,
                                       input int div);
        return (meas_period == div) &&
               (meas_high >= (div / 2)) &&
               (meas_high <= ((div + 1) / 2));
    endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// ---------------------------------------------------------------------------
// sync_rise_detect
// Brings an asynchronous level into the clkin domain through a two-flop
// synchronizer (s1, s2), keeps one history flop (s3) and flags a rising edge
// when s2 is high and s3 is still low.
//   clkin    : source clock
//   reset    : synchronous, active-low reset
//   async_in : asynchronous input level
//   level    : synchronized level (s2)
//   rise     : one-cycle pulse on a synchronized 0->1 transition
// ---------------------------------------------------------------------------
module sync_rise_detect (
    input  logic clkin,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = async_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clkin) begin
        if (!reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign level = s2_q;
    assign rise  = s2_q & ~s3_q;

endmodule

// File: rtl/clock_divide_monitor.sv
// ---------------------------------------------------------------------------
// clock_divide_monitor
// Receiving-end checker for a divided clock. Measures the period and high
// time of each div_clk cycle in clkin cycles, declares lock after a run of
// good periods and reports bad periods and a stuck clock.
//   clkin      : source clock, the only clock
//   reset      : synchronous, active-low reset
//   div_clk    : divided clock under test (asynchronous data)
//   period     : last measured period in clkin cycles
//   high_cnt   : clkin cycles div_clk was high in the last period
//   meas_valid : one-cycle pulse when period/high_cnt update
//   locked     : LOCK_COUNT consecutive good periods since the last error
//   err        : one-cycle pulse on a bad period or a stuck timeout
//   stuck      : no rising edge for TIMEOUT cycles, held until the next rise
//   err_cnt    : saturating count of err pulses
// ---------------------------------------------------------------------------
module clock_divide_monitor
    import clk_div_pkg::*;
#(
    parameter int DIV        = DIV_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int LOCK_COUNT = LOCK_COUNT_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             div_clk,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_cnt,
    output logic             meas_valid,
    output logic             locked,
    output logic             err,
    output logic             stuck,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam int               RUN_W    = 4;
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
    localparam logic [RUN_W-1:0] LOCK_TGT = RUN_W'(LOCK_COUNT);

    logic sync_level;
    logic rise_pulse;

    sync_rise_detect u_sync (
        .clkin    (clkin),
        .reset    (reset),
        .async_in (div_clk),
        .level    (sync_level),
        .rise     (rise_pulse)
    );

    // Measurement counters and the one-stage event pipeline feeding the FSM.
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] cap_period_q, cap_period_d;
    logic [CNT_W-1:0] cap_high_q, cap_high_d;
    logic             rise_p_q, rise_p_d;
    logic             good_p_q, good_p_d;
    logic             timeout_p_q, timeout_p_d;

    // Both counters restart at 1 on a rise: the rise cycle itself is the
    // first cycle of the new period and s2 is known high in it. The window
    // just closed is captured and judged here, and the FSM acts on it one
    // cycle later so that reporting and timeouts share the same timing.
    // A rise on the timeout cycle wins over the timeout.
    always_comb begin
        cyc_d        = cyc_q;
        high_d       = high_q;
        cap_period_d = cap_period_q;
        cap_high_d   = cap_high_q;
        rise_p_d     = rise_pulse;
        good_p_d     = 1'b0;
        timeout_p_d  = 1'b0;

        if (rise_pulse) begin
            cyc_d        = CNT_ONE;
            high_d       = CNT_ONE;
            cap_period_d = cyc_q;
            cap_high_d   = high_q;
            good_p_d     = period_ok(int'(cyc_q), int'(high_q), DIV);
        end else begin
            if (cyc_q != CNT_MAX) begin
                cyc_d = cyc_q + CNT_ONE;
            end
            if (sync_level && (high_q != CNT_MAX)) begin
                high_d = high_q + CNT_ONE;
            end
            timeout_p_d = (int'(cyc_q) == TIMEOUT);
        end
    end

    always_ff @(posedge clkin) begin
        if (!reset) begin
            cyc_q        <= '0;
            high_q       <= '0;
            cap_period_q <= '0;
            cap_high_q   <= '0;
            rise_p_q     <= 1'b0;
            good_p_q     <= 1'b0;
            timeout_p_q  <= 1'b0;
        end else begin
            cyc_q        <= cyc_d;
            high_q       <= high_d;
            cap_period_q <= cap_period_d;
            cap_high_q   <= cap_high_d;
            rise_p_q     <= rise_p_d;
            good_p_q     <= good_p_d;
            timeout_p_q  <= timeout_p_d;
        end
    end

    // Monitor FSM with registered outputs.
    mon_state_t       state_q, state_d;
    logic [RUN_W-1:0] good_run_q, good_run_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             meas_valid_q, meas_valid_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             stuck_q, stuck_d;

    // The first rise out of IDLE only opens a window, so nothing is reported
    // for it. In LOCKED the good run is already complete and is left alone.
    always_comb begin
        state_d      = state_q;
        good_run_d   = good_run_q;
        period_d     = period_q;
        high_cnt_d   = high_cnt_q;
        err_cnt_d    = err_cnt_q;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;
        err_d        = 1'b0;
        stuck_d      = stuck_q;

        case (state_q)
            IDLE: begin
                if (rise_p_q) begin
                    state_d    = MEASURE;
                    stuck_d    = 1'b0;
                    good_run_d = '0;
                end
            end
            MEASURE, LOCKED: begin
                if (rise_p_q) begin
                    meas_valid_d = 1'b1;
                    period_d     = cap_period_q;
                    high_cnt_d   = cap_high_q;
                    if (good_p_q) begin
                        if (state_q == MEASURE) begin
                            good_run_d = good_run_q + RUN_ONE;
                            if ((good_run_q + RUN_ONE) == LOCK_TGT) begin
                                state_d  = LOCKED;
                                locked_d = 1'b1;
                            end
                        end
                    end else begin
                        err_d      = 1'b1;
                        good_run_d = '0;
                        locked_d   = 1'b0;
                        state_d    = MEASURE;
                    end
                end else if (timeout_p_q) begin
                    err_d      = 1'b1;
                    stuck_d    = 1'b1;
                    locked_d   = 1'b0;
                    good_run_d = '0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (err_d && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clkin) begin
        if (!reset) begin
            state_q      <= IDLE;
            good_run_q   <= '0;
            period_q     <= '0;
            high_cnt_q   <= '0;
            err_cnt_q    <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            stuck_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            good_run_q   <= good_run_d;
            period_q     <= period_d;
            high_cnt_q   <= high_cnt_d;
            err_cnt_q    <= err_cnt_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
            stuck_q      <= stuck_d;
        end
    end

    assign period     = period_q;
    assign high_cnt   = high_cnt_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign err        = err_q;
    assign stuck      = stuck_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_clock_divide_monitor.sv
// ---------------------------------------------------------------------------
// tb_clock_divide_monitor
// Drives one shared div_clk/reset into three monitor instances:
//   dut3 : DIV=3, CNT_W=8
//   dut4 : DIV=4, CNT_W=8
//   dut2 : DIV=3, CNT_W=2 (err_cnt saturation)
// Every meas_valid/err pulse is logged and compared with hand-built lists.
// ---------------------------------------------------------------------------
module tb_clock_divide_monitor;

    logic clkin  = 1'b0;
    logic reset  = 1'b0;
    logic divClk = 1'b0;

    always #5 clkin = ~clkin;

    logic [7:0] period3, high3, errCnt3;
    logic       mv3, locked3, err3, stuck3;
    logic [7:0] period4, high4, errCnt4;
    logic       mv4, locked4, err4, stuck4;
    logic [1:0] period2, high2, errCnt2;
    logic       mv2, locked2, err2, stuck2;

    clock_divide_monitor #(.DIV(3), .CNT_W(8), .LOCK_COUNT(4), .TIMEOUT(12)) dut3 (
        .clkin(clkin), .reset(reset), .div_clk(divClk),
        .period(period3), .high_cnt(high3), .meas_valid(mv3), .locked(locked3),
        .err(err3), .stuck(stuck3), .err_cnt(errCnt3)
    );

    clock_divide_monitor #(.DIV(4), .CNT_W(8), .LOCK_COUNT(4), .TIMEOUT(12)) dut4 (
        .clkin(clkin), .reset(reset), .div_clk(divClk),
        .period(period4), .high_cnt(high4), .meas_valid(mv4), .locked(locked4),
        .err(err4), .stuck(stuck4), .err_cnt(errCnt4)
    );

    clock_divide_monitor #(.DIV(3), .CNT_W(2), .LOCK_COUNT(4), .TIMEOUT(12)) dut2 (
        .clkin(clkin), .reset(reset), .div_clk(divClk),
        .period(period2), .high_cnt(high2), .meas_valid(mv2), .locked(locked2),
        .err(err2), .stuck(stuck2), .err_cnt(errCnt2)
    );

    typedef struct {
        int   cyc;
        logic mv;
        logic er;
        logic lk;
        logic st;
        int   per;
        int   hi;
        int   ec;
    } evt_t;

    typedef struct {
        logic [15:0] pat;
        int          len;
        int          reps;
    } seg_t;

    evt_t ev3[$], ev4[$], ev2[$], gotQ[$], wantQ[$];
    seg_t segQ[$];

    int cycNum = 0;
    int errors = 0;
    int checks = 0;

    // Counts clkin rising edges so event timing can be compared.
    always @(posedge clkin) cycNum <= cycNum + 1;

    // Logs every reported event of each instance, sampled mid-cycle.
    always @(negedge clkin) begin
        if (mv3 || err3)
            ev3.push_back('{cycNum, mv3, err3, locked3, stuck3, int'(period3), int'(high3), int'(errCnt3)});
        if (mv4 || err4)
            ev4.push_back('{cycNum, mv4, err4, locked4, stuck4, int'(period4), int'(high4), int'(errCnt4)});
        if (mv2 || err2)
            ev2.push_back('{cycNum, mv2, err2, locked2, stuck2, int'(period2), int'(high2), int'(errCnt2)});
    end

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drives pat[len-1] first, one bit per clkin cycle, reps times.
    task automatic applyStimulus(input logic [15:0] pat, input int len, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = len - 1; i >= 0; i--) begin
                divClk = pat[i];
                tick();
            end
        end
    endtask

    task automatic runSegments();
        foreach (segQ[i]) applyStimulus(segQ[i].pat, segQ[i].len, segQ[i].reps);
    endtask

    task automatic doReset();
        reset  = 1'b0;
        divClk = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic want(input logic mv, input logic er, input logic lk, input logic st,
                        input int per, input int hi, input int ec);
        wantQ.push_back('{0, mv, er, lk, st, per, hi, ec});
    endtask

    task automatic checkEvents(input string tag);
        int n;
        checkOutput({tag, " event count"}, gotQ.size(), wantQ.size());
        n = (gotQ.size() < wantQ.size()) ? gotQ.size() : wantQ.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s[%0d] meas_valid", tag, i), int'(gotQ[i].mv), int'(wantQ[i].mv));
            checkOutput($sformatf("%s[%0d] err", tag, i), int'(gotQ[i].er), int'(wantQ[i].er));
            checkOutput($sformatf("%s[%0d] locked", tag, i), int'(gotQ[i].lk), int'(wantQ[i].lk));
            checkOutput($sformatf("%s[%0d] stuck", tag, i), int'(gotQ[i].st), int'(wantQ[i].st));
            checkOutput($sformatf("%s[%0d] period", tag, i), gotQ[i].per, wantQ[i].per);
            checkOutput($sformatf("%s[%0d] high_cnt", tag, i), gotQ[i].hi, wantQ[i].hi);
            checkOutput($sformatf("%s[%0d] err_cnt", tag, i), gotQ[i].ec, wantQ[i].ec);
        end
    endtask

    initial begin
        int r2Drive;
        int r15Drive;
        int gap;

        // Lock, one long period while locked, re-lock, stuck clock, recovery.
        $display("[TB] DIV=3 lock / bad period / stuck");
        doReset();
        ev3.delete();
        applyStimulus(16'b110, 3, 1);
        r2Drive = cycNum;
        applyStimulus(16'b110, 3, 7);
        applyStimulus(16'b1100, 4, 1);
        applyStimulus(16'b110, 3, 5);
        r15Drive = cycNum;
        applyStimulus(16'b110, 3, 1);
        applyStimulus(16'b0, 1, 15);
        checkOutput("stuck after idle hold", int'(stuck3), 1);
        checkOutput("locked after idle hold", int'(locked3), 0);
        applyStimulus(16'b110, 3, 2);
        checkOutput("stuck cleared by rise", int'(stuck3), 0);
        applyStimulus(16'b0, 1, 6);

        wantQ.delete();
        for (int i = 0; i < 8; i++) want(1, 0, (i >= 3), 0, 3, 2, 0);
        want(1, 1, 0, 0, 4, 2, 1);
        for (int i = 0; i < 5; i++) want(1, 0, (i >= 3), 0, 3, 2, 1);
        want(0, 1, 0, 1, 3, 2, 2);
        want(1, 0, 0, 0, 3, 2, 2);
        gotQ = ev3;
        checkEvents("A");
        gap = (gotQ.size() > 0) ? gotQ[0].cyc - r2Drive : -1;
        checkOutput("A first meas latency", gap, 4);
        gap = (gotQ.size() > 13) ? gotQ[13].cyc - r15Drive : -1;
        checkOutput("A last meas latency", gap, 4);
        gap = (gotQ.size() > 14) ? gotQ[14].cyc - gotQ[13].cyc : -1;
        checkOutput("A timeout gap", gap, 12);

        // DIV=4: 75% duty is rejected every time, 50% duty locks.
        $display("[TB] DIV=4 duty check");
        doReset();
        ev4.delete();
        segQ.delete();
        segQ.push_back('{16'b1110, 4, 5});
        segQ.push_back('{16'b1100, 4, 6});
        segQ.push_back('{16'b0, 1, 6});
        runSegments();
        wantQ.delete();
        for (int i = 0; i < 5; i++) want(1, 1, 0, 0, 4, 3, i + 1);
        for (int i = 0; i < 5; i++) want(1, 0, (i >= 3), 0, 4, 2, 5);
        gotQ = ev4;
        checkEvents("B");
        checkOutput("B final locked", int'(locked4), 1);

        // CNT_W=2: err_cnt saturates at 3.
        $display("[TB] CNT_W=2 saturation");
        doReset();
        ev2.delete();
        segQ.delete();
        segQ.push_back('{16'b10, 2, 7});
        segQ.push_back('{16'b0, 1, 6});
        runSegments();
        wantQ.delete();
        for (int i = 0; i < 6; i++) want(1, 1, 0, 0, 2, 1, (i < 3) ? i + 1 : 3);
        gotQ = ev2;
        checkEvents("C");

        // Reset while locked with two errors recorded.
        $display("[TB] reset while locked");
        doReset();
        ev3.delete();
        segQ.delete();
        segQ.push_back('{16'b110, 3, 1});
        segQ.push_back('{16'b10, 2, 2});
        segQ.push_back('{16'b110, 3, 6});
        segQ.push_back('{16'b0, 1, 2});
        runSegments();
        wantQ.delete();
        want(1, 0, 0, 0, 3, 2, 0);
        want(1, 1, 0, 0, 2, 1, 1);
        want(1, 1, 0, 0, 2, 1, 2);
        for (int i = 0; i < 5; i++) want(1, 0, (i >= 3), 0, 3, 2, 2);
        gotQ = ev3;
        checkEvents("E pre");
        checkOutput("E locked before reset", int'(locked3), 1);
        checkOutput("E err_cnt before reset", int'(errCnt3), 2);

        reset  = 1'b0;
        divClk = 1'b1;
        tick();
        checkOutput("E reset period", int'(period3), 0);
        checkOutput("E reset high_cnt", int'(high3), 0);
        checkOutput("E reset meas_valid", int'(mv3), 0);
        checkOutput("E reset locked", int'(locked3), 0);
        checkOutput("E reset err", int'(err3), 0);
        checkOutput("E reset stuck", int'(stuck3), 0);
        checkOutput("E reset err_cnt", int'(errCnt3), 0);
        reset = 1'b1;
        ev3.delete();
        applyStimulus(16'b0, 1, 2);
        applyStimulus(16'b110, 3, 3);
        applyStimulus(16'b0, 1, 6);
        wantQ.delete();
        want(1, 0, 0, 0, 3, 2, 0);
        want(1, 0, 0, 0, 3, 2, 0);
        gotQ = ev3;
        checkEvents("E post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clock_divide_monitor.md
Name: clock_divide_monitor

Overview:
Receiving-end checker for a divided clock. It samples a divided clock (e.g. the divide-by-3 output) in the fast source-clock domain and measures the period and high time of each cycle in source-clock cycles. It declares lock after a run of good periods, and flags period/duty errors and a stuck clock. It sits beside any clock divider as a built-in self-check, with counters readable for debug.

Parameters:
DIV, 3, expected period of div_clk in clkin cycles (2..2^CNT_W-1)
CNT_W, 8, width of measurement and error counters
LOCK_COUNT, 4, consecutive good periods required to assert locked (1..15)
TIMEOUT, 12, clkin cycles without a detected rising edge before stuck is declared (> DIV)

Ports:
clkin  input  1  source clock; the only clock
reset  input  1  synchronous, active-low reset
div_clk  input  1  divided clock under test, treated as asynchronous data
period  output  CNT_W  last measured period, in clkin cycles
high_cnt  output  CNT_W  clkin cycles div_clk was sampled high in the last period
meas_valid  output  1  one-cycle pulse when period/high_cnt update
locked  output  1  LOCK_COUNT consecutive good periods seen since the last error
err  output  1  one-cycle pulse on a bad period or on a stuck timeout
stuck  output  1  no rising edge for TIMEOUT cycles; sticky until the next rising edge
err_cnt  output  CNT_W  saturating count of err pulses

Behaviour:
- Reset (reset==0 at a clkin rising edge):
  - all outputs 0; sync flops 0; state IDLE; internal counters 0.
  - Applies mid-operation too; the cycle after reset release behaves as power-up.
- Input path: 2-flop synchronizer s1→s2, then history flop s3.
  - Rising edge detected when s2=1 and s3=0.
  - meas_valid/err rise 3 clkin cycles after the clkin edge that first samples div_clk high at s1.
- Counting:
  - Cycle counter: at a detected rise the next cycle holds 1; otherwise increments each cycle. Saturates at 2^CNT_W-1.
  - High counter: same restart rule, increments only when s2=1.
  - Period = number of clkin cycles between consecutive detected rises.
- Good period: period==DIV and floor(DIV/2) <= high_cnt <= ceil(DIV/2).
- FSM states: IDLE, MEASURE, LOCKED. good_run counter is 0..LOCK_COUNT.
  - IDLE: first detected rise → MEASURE. No measurement is emitted (partial period). stuck clears on that rise.
  - MEASURE: on each rise, emit meas_valid with period/high_cnt.
    - Good: good_run++. When it reaches LOCK_COUNT → LOCKED; locked=1 in the same cycle as that meas_valid.
    - Bad: err pulse, good_run=0, stay in MEASURE.
  - LOCKED: on each rise, emit meas_valid.
    - Bad: err pulse, locked=0 in the same cycle, good_run=0 → MEASURE.
  - Any state except IDLE: cycle counter reaching TIMEOUT with no rise → err pulse (once), stuck=1, locked=0, good_run=0 → IDLE.
- Simultaneous events: a rise on the timeout cycle counts as a rise; no timeout is taken.
- err_cnt increments on every err pulse and holds at 2^CNT_W-1. It is cleared only by reset.
- period/high_cnt hold their value between meas_valid pulses.

Decomposition:
- Package clk_div_pkg holds:
  - typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} mon_state_t
  - default constants DIV_DEF=3, CNT_W_DEF=8, LOCK_COUNT_DEF=4
- Sub-module sync_rise_detect: clkin, reset, async input → synchronized level s2 and one-cycle rise pulse. Reusable for other divider outputs.
- The counters and FSM stay in clock_divide_monitor.

Test Plan:
- DIV=3. After reset release, drive div_clk synchronous pattern 1,1,0 repeating → meas_valid every 3 cycles with period=3, high_cnt=2. locked=1 on the 4th meas_valid. err never pulses; err_cnt=0.
- While locked, insert one pattern 1,1,0,0 → that meas_valid shows period=4. err pulses in the same cycle, locked→0, err_cnt=1. Resume 1,1,0 → locked=1 again on the 4th subsequent good meas_valid.
- While locked, hold div_clk=0 for 15 cycles → err pulses once, 12 cycles after the last counted rise. stuck=1, locked=0, err_cnt+1. On the next rise stuck→0 with no meas_valid; the following rise produces meas_valid.
- DIV=4 instance, pattern 1,1,1,0 → period=4, high_cnt=3 (outside 2..2) → err on every meas_valid, locked stays 0. Pattern 1,1,0,0 → locks after 4 periods.
- Assert reset for 1 cycle while locked with err_cnt=2 and div_clk high → next cycle all outputs 0. The first rise after release gives no meas_valid; the second rise gives period=3.
- CNT_W=2, 5 consecutive bad periods → err_cnt counts 1,2,3 then stays at 3.
